// File: rtl/chip8_pkg.sv
// +-----------------------------------------------------------------------+
// | chip8_pkg                                                             |
// | Shared constants, the CHIP-8 font table and the responder states.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package chip8_pkg;

  localparam logic [11:0] PROG_BASE_DEF = 12'h200;
  localparam int          FONT_BYTES    = 80;

  // Digits 0..F, five rows each, glyph in the upper nibble.
  localparam logic [7:0] c_font_table [0:FONT_BYTES-1] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FONT  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } mem_state_t;

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    if (idx < 7'(FONT_BYTES)) begin
      return c_font_table[idx];
    end
    return 8'h00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chip8_font_rom.sv
// +-----------------------------------------------------------------------+
// | chip8_font_rom                                                        |
// | Combinational 80-entry font lookup; indices past the table read 0.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module chip8_font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] idx,
  output logic [7:0] data
);

  assign data = font_byte(idx);

endmodule

`default_nettype wire

// File: rtl/chip8_mem_responder.sv
// +-----------------------------------------------------------------------+
// | chip8_mem_responder                                                   |
// | 4 KiB CHIP-8 RAM with clear/font/program bring-up before CPU release. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module chip8_mem_responder
  import chip8_pkg::*;
#(
  parameter logic        CLEAR_EN  = 1'b1,
  parameter logic [11:0] FONT_BASE = 12'h000,
  parameter logic [11:0] PROG_BASE = PROG_BASE_DEF
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] mem_addr,
  input  logic [7:0]  mem_write_data,
  input  logic        mem_write_en,
  output logic [7:0]  mem_read_data,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_run,
  output logic [11:0] prog_len,
  output logic        wr_violation
);

  localparam logic [11:0] c_font_last = 12'(FONT_BYTES - 1);
  localparam logic [11:0] c_addr_top  = 12'hFFF;

  mem_state_t  r_state;
  logic [11:0] r_cnt;
  logic [11:0] r_ptr;
  logic [11:0] r_prog_len;
  logic        r_wr_violation;
  logic        r_load_ready;
  logic        r_cpu_run;

  logic [7:0]  r_ram [0:4095];

  logic        w_we;
  logic [11:0] w_waddr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_font_data;
  logic        w_load_fire;
  logic        w_cpu_wr_ok;

  chip8_font_rom u_font_rom (
    .idx  (r_cnt[6:0]),
    .data (w_font_data)
  );

  assign w_load_fire = load_valid & r_load_ready;
  assign w_cpu_wr_ok = (mem_addr >= PROG_BASE);

  // Single RAM write port, owned by whichever phase is active.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cnt;
    w_wdata = 8'h00;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = 8'h00;
      end
      ST_FONT: begin
        w_we    = 1'b1;
        w_waddr = FONT_BASE + r_cnt;
        w_wdata = w_font_data;
      end
      ST_LOAD: begin
        w_we    = w_load_fire;
        w_waddr = r_ptr;
        w_wdata = load_data;
      end
      ST_RUN: begin
        w_we    = mem_write_en & w_cpu_wr_ok;
        w_waddr = mem_addr;
        w_wdata = mem_write_data;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_ram[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= CLEAR_EN ? ST_CLEAR : ST_FONT;
      r_cnt          <= 12'd0;
      r_ptr          <= PROG_BASE;
      r_prog_len     <= 12'd0;
      r_wr_violation <= 1'b0;
      r_load_ready   <= 1'b0;
      r_cpu_run      <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // The counter wraps to 0 on the last clear write, ready for FONT.
          r_cnt <= r_cnt + 12'd1;
          if (r_cnt == c_addr_top) begin
            r_state <= ST_FONT;
          end
        end
        ST_FONT: begin
          if (r_cnt == c_font_last) begin
            r_cnt        <= 12'd0;
            r_state      <= ST_LOAD;
            r_load_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 12'd1;
          end
        end
        ST_LOAD: begin
          if (w_load_fire) begin
            r_ptr      <= r_ptr + 12'd1;
            r_prog_len <= r_prog_len + 12'd1;
            // Leaving at the top of memory stops the pointer wrapping onto the font.
            if (load_last || (r_ptr == c_addr_top)) begin
              r_state      <= ST_RUN;
              r_load_ready <= 1'b0;
              r_cpu_run    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (mem_write_en && !w_cpu_wr_ok) begin
            r_wr_violation <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign mem_read_data = (r_state == ST_RUN) ? r_ram[mem_addr] : 8'h00;
  assign load_ready    = r_load_ready;
  assign cpu_run       = r_cpu_run;
  assign prog_len      = r_prog_len;
  assign wr_violation  = r_wr_violation;

endmodule

`default_nettype wire

// File: tb/tb_chip8_mem_responder.sv
// +-----------------------------------------------------------------------+
// | tb_chip8_mem_responder                                                |
// | Randomized bench with a byte-array memory model; two DUT configs.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_chip8_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: no clear phase.
  logic        a_reset_n, a_mem_write_en, a_load_valid, a_load_last;
  logic [11:0] a_mem_addr;
  logic [7:0]  a_mem_write_data, a_load_data, a_rdata;
  logic        a_load_ready, a_cpu_run, a_wr_violation;
  logic [11:0] a_prog_len;

  // Instance B: clear phase enabled.
  logic        b_reset_n, b_mem_write_en, b_load_valid, b_load_last;
  logic [11:0] b_mem_addr;
  logic [7:0]  b_mem_write_data, b_load_data, b_rdata;
  logic        b_load_ready, b_cpu_run, b_wr_violation;
  logic [11:0] b_prog_len;

  chip8_mem_responder #(.CLEAR_EN(1'b0), .FONT_BASE(12'h000), .PROG_BASE(12'h200)) u_dut_a (
    .clk(clk), .reset_n(a_reset_n), .mem_addr(a_mem_addr), .mem_write_data(a_mem_write_data),
    .mem_write_en(a_mem_write_en), .mem_read_data(a_rdata), .load_valid(a_load_valid),
    .load_data(a_load_data), .load_last(a_load_last), .load_ready(a_load_ready),
    .cpu_run(a_cpu_run), .prog_len(a_prog_len), .wr_violation(a_wr_violation)
  );

  chip8_mem_responder #(.CLEAR_EN(1'b1), .FONT_BASE(12'h000), .PROG_BASE(12'h200)) u_dut_b (
    .clk(clk), .reset_n(b_reset_n), .mem_addr(b_mem_addr), .mem_write_data(b_mem_write_data),
    .mem_write_en(b_mem_write_en), .mem_read_data(b_rdata), .load_valid(b_load_valid),
    .load_data(b_load_data), .load_last(b_load_last), .load_ready(b_load_ready),
    .cpu_run(b_cpu_run), .prog_len(b_prog_len), .wr_violation(b_wr_violation)
  );

  // Reference memory: contents plus a flag for bytes whose value is defined.
  logic [7:0] m_ram   [4096];
  bit         m_known [4096];
  int         m_ptr;
  int         exp_len;
  bit         exp_viol;

  logic [7:0] font_ref [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_bringup();
    for (int i = 0; i < 80; i++) begin
      m_ram[i]   = font_ref[i];
      m_known[i] = 1'b1;
    end
    m_ptr    = 'h200;
    exp_len  = 0;
    exp_viol = 1'b0;
  endtask

  task automatic a_send(input logic [7:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    a_load_valid = 1'b1;
    a_load_data  = d;
    a_load_last  = last;
    for (int w = 0; w < 20 && !ok; w++) begin
      if (a_load_ready) ok = 1'b1;
      tick();
    end
    a_load_valid = 1'b0;
    a_load_last  = 1'b0;
    if (ok) begin
      m_ram[m_ptr]   = d;
      m_known[m_ptr] = 1'b1;
      m_ptr++;
      exp_len++;
    end else begin
      check_eq("a_handshake_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic b_send(input logic [7:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    b_load_valid = 1'b1;
    b_load_data  = d;
    b_load_last  = last;
    for (int w = 0; w < 20 && !ok; w++) begin
      if (b_load_ready) ok = 1'b1;
      tick();
    end
    b_load_valid = 1'b0;
    b_load_last  = 1'b0;
    if (!ok) check_eq("b_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic a_rd(input string tag, input int addr);
    a_mem_addr = 12'(addr);
    tick();
    if (m_known[addr]) check_eq(tag, 32'(a_rdata), 32'(m_ram[addr]));
  endtask

  task automatic b_rd(input string tag, input int addr, input logic [7:0] exp);
    b_mem_addr = 12'(addr);
    tick();
    check_eq(tag, 32'(b_rdata), 32'(exp));
  endtask

  task automatic a_cpu_write(input int addr, input logic [7:0] d);
    a_mem_addr       = 12'(addr);
    a_mem_write_data = d;
    a_mem_write_en   = 1'b1;
    #1;
    if (m_known[addr]) check_eq("rdw_old_byte", 32'(a_rdata), 32'(m_ram[addr]));
    tick();
    a_mem_write_en = 1'b0;
    if (addr >= 'h200) begin
      m_ram[addr]   = d;
      m_known[addr] = 1'b1;
    end else begin
      exp_viol = 1'b1;
    end
    check_eq("wr_violation", 32'(a_wr_violation), 32'(exp_viol));
    #1;
    if (m_known[addr]) check_eq("rdw_new_byte", 32'(a_rdata), 32'(m_ram[addr]));
  endtask

  task automatic b_bringup();
    repeat (4175) tick();
    check_eq("b_ready_before_4176", 32'(b_load_ready), 32'd0);
    check_eq("b_run_in_bringup", 32'(b_cpu_run), 32'd0);
    tick();
    check_eq("b_ready_at_4176", 32'(b_load_ready), 32'd1);
  endtask

  initial begin
    a_reset_n = 1'b0; a_mem_write_en = 1'b0; a_load_valid = 1'b0; a_load_last = 1'b0;
    a_mem_addr = 12'h000; a_mem_write_data = 8'h00; a_load_data = 8'h00;
    b_reset_n = 1'b0; b_mem_write_en = 1'b0; b_load_valid = 1'b0; b_load_last = 1'b0;
    b_mem_addr = 12'h000; b_mem_write_data = 8'h00; b_load_data = 8'h00;
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;

    repeat (3) tick();
    check_eq("a_rst_cpu_run", 32'(a_cpu_run), 32'd0);
    check_eq("a_rst_load_ready", 32'(a_load_ready), 32'd0);
    check_eq("a_rst_prog_len", 32'(a_prog_len), 32'd0);
    check_eq("a_rst_wr_violation", 32'(a_wr_violation), 32'd0);
    check_eq("a_rst_read_forced", 32'(a_rdata), 32'd0);
    check_eq("b_rst_cpu_run", 32'(b_cpu_run), 32'd0);
    check_eq("b_rst_load_ready", 32'(b_load_ready), 32'd0);

    // ---- Instance A: font-only bring-up and the four-byte program.
    a_reset_n = 1'b1;
    repeat (79) tick();
    check_eq("a_ready_before_80", 32'(a_load_ready), 32'd0);
    check_eq("a_read_forced_font", 32'(a_rdata), 32'd0);
    tick();
    check_eq("a_ready_at_80", 32'(a_load_ready), 32'd1);
    model_bringup();

    a_send(8'h00, 1'b0);
    a_send(8'hE0, 1'b0);
    for (int s = 0; s < 10; s++) begin
      a_load_data = 8'($urandom);
      a_load_last = 1'($urandom);
      tick();
      check_eq("stall_prog_len", 32'(a_prog_len), 32'd2);
    end
    a_load_last = 1'b0;
    check_eq("stall_ready_held", 32'(a_load_ready), 32'd1);
    check_eq("load_read_forced", 32'(a_rdata), 32'd0);
    a_send(8'h60, 1'b0);
    check_eq("run_before_last", 32'(a_cpu_run), 32'd0);
    a_send(8'h05, 1'b1);
    check_eq("run_after_last", 32'(a_cpu_run), 32'd1);
    check_eq("ready_after_last", 32'(a_load_ready), 32'd0);
    check_eq("prog_len_4", 32'(a_prog_len), 32'(exp_len));

    for (int i = 0; i < 80; i++) a_rd("font_byte", i);
    for (int i = 'h200; i < 'h204; i++) a_rd("prog_byte", i);

    a_load_valid = 1'b1;
    repeat (3) tick();
    a_load_valid = 1'b0;
    check_eq("run_ignores_valid", 32'(a_prog_len), 32'(exp_len));

    a_cpu_write('h300, 8'hAB);
    a_cpu_write('h010, 8'h11);
    a_cpu_write('h200, 8'h3C);
    a_cpu_write('h1FF, 8'h77);
    for (int i = 0; i < 300; i++) begin
      int addr;
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 'h1FF))
                                         : int'($urandom_range('h200, 'hFFF));
      a_cpu_write(addr, 8'($urandom));
    end
    for (int i = 0; i < 80; i++) a_rd("font_after_writes", i);

    // ---- Instance A: rerun, fill the whole program area without load_last.
    a_reset_n = 1'b0;
    #1;
    check_eq("a_rerst_cpu_run", 32'(a_cpu_run), 32'd0);
    check_eq("a_rerst_prog_len", 32'(a_prog_len), 32'd0);
    check_eq("a_rerst_wr_violation", 32'(a_wr_violation), 32'd0);
    tick();
    a_reset_n = 1'b1;
    repeat (80) tick();
    check_eq("a_rerun_ready", 32'(a_load_ready), 32'd1);
    model_bringup();

    for (int k = 0; k < 'hE00; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          a_load_data = 8'($urandom);
          tick();
        end
      end
      if (k == 'hDFF) begin
        check_eq("full_run_before_top", 32'(a_cpu_run), 32'd0);
        check_eq("full_len_before_top", 32'(a_prog_len), 32'hDFF);
      end
      a_send(8'($urandom), 1'b0);
    end
    check_eq("full_run_after_top", 32'(a_cpu_run), 32'd1);
    check_eq("full_prog_len", 32'(a_prog_len), 32'hE00);
    a_load_valid = 1'b1;
    a_load_data  = 8'h99;
    repeat (5) tick();
    a_load_valid = 1'b0;
    check_eq("full_ignores_valid", 32'(a_prog_len), 32'hE00);
    check_eq("full_ready_low", 32'(a_load_ready), 32'd0);
    for (int i = 0; i < 'h1000; i++) a_rd("full_mem", i);

    // ---- Instance B: clear, poison, reset mid-load, rerun.
    b_reset_n = 1'b1;
    b_bringup();
    for (int i = 0; i < 8; i++) b_send(8'($urandom) | 8'h01, 1'b0);
    check_eq("b_poison_len", 32'(b_prog_len), 32'd8);
    #2;
    b_reset_n = 1'b0;
    #1;
    check_eq("b_midload_rst_ready", 32'(b_load_ready), 32'd0);
    check_eq("b_midload_rst_len", 32'(b_prog_len), 32'd0);
    check_eq("b_midload_rst_run", 32'(b_cpu_run), 32'd0);
    tick();
    b_reset_n = 1'b1;
    b_bringup();
    b_send(8'h5A, 1'b1);
    check_eq("b_run", 32'(b_cpu_run), 32'd1);
    check_eq("b_prog_len", 32'(b_prog_len), 32'd1);
    b_rd("b_new_byte", 'h200, 8'h5A);
    for (int i = 'h201; i < 'h208; i++) b_rd("b_cleared_poison", i, 8'h00);
    for (int i = 0; i < 5; i++) b_rd("b_font", 'h04B + i, font_ref[75 + i]);
    for (int i = 0; i < 32; i++) b_rd("b_cleared_rand", int'($urandom_range('h208, 'hFFF)), 8'h00);
    for (int i = 0; i < 16; i++) b_rd("b_cleared_low", int'($urandom_range(80, 'h1FF)), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
